// File: rtl/tea_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tea_pkg: shared TEA constants and the arbiter/sequencer state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
    localparam int          TEA_ROUNDS = 32;
    localparam int          TEA_BLK_W  = 64;
    localparam int          TEA_KEY_W  = 128;

    typedef enum logic [2:0] {
        WAIT_CORE = 3'd0,
        ARB       = 3'd1,
        START     = 3'd2,
        BUSY      = 3'd3,
        RESP      = 3'd4
    } tea_state_e;

endpackage
`default_nettype wire

// File: rtl/tea_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tea_rr_arbiter: combinational round-robin pick, searching upward from i_ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module tea_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
                o_any                            = 1'b1;
                o_grant[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                            = IW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tea_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tea_arbiter: shares one TEA core among NUM_REQ requesters (round robin);
// optional BUSY watchdog enabled by TEA_ARB_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module tea_arbiter
    import tea_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [31:0] DELTA       = TEA_DELTA,
    parameter int          TIMEOUT_CYC = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [TEA_BLK_W*NUM_REQ-1:0]   req_data,
    input  logic [TEA_KEY_W*NUM_REQ-1:0]   req_key,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [TEA_BLK_W-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic                           rsp_err,
    output logic                           core_start,
    output logic [TEA_BLK_W-1:0]           core_data,
    output logic [TEA_KEY_W-1:0]           core_key,
    output logic [31:0]                    core_delta,
    input  logic                           core_done,
    input  logic [TEA_BLK_W-1:0]           core_result,
    output logic                           busy
);

    localparam int IW = $clog2(NUM_REQ);

    tea_state_e             r_state, w_next;
    logic [IW-1:0]          r_ptr, r_id, w_idx;
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_any, w_accept, w_done_ok, r_seen_low;
    logic [TEA_BLK_W-1:0]   r_data, r_rsp_data;
    logic [TEA_KEY_W-1:0]   r_key;
    logic [TEA_BLK_W-1:0]   w_req_data [NUM_REQ];
    logic [TEA_KEY_W-1:0]   w_req_key  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_data[gi*TEA_BLK_W +: TEA_BLK_W];
            assign w_req_key[gi]  = req_key[gi*TEA_KEY_W +: TEA_KEY_W];
        end
    endgenerate

    tea_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept  = (r_state == ARB) && w_any;
    // A done seen before the core has dropped it belongs to the previous job.
    assign w_done_ok = (r_state == BUSY) && core_done && r_seen_low;

`ifdef TEA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err, w_timeout;

    assign w_timeout = (r_state == BUSY) && (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == START)
                r_cnt <= '0;
            else if (r_state == BUSY)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout && !w_done_ok)
                r_err <= 1'b1;
            else if ((r_state == RESP) && rsp_ready)
                r_err <= 1'b0;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > TEA_ROUNDS);
    assign rsp_err      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_CORE: if (core_done) w_next = ARB;
            ARB:       if (w_any) w_next = START;
            START:     w_next = BUSY;
            BUSY: begin
                if (w_done_ok) w_next = RESP;
`ifdef TEA_ARB_TIMEOUT_EN
                else if (w_timeout) w_next = RESP;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = ARB;
`ifdef TEA_ARB_TIMEOUT_EN
                    if (r_err) w_next = WAIT_CORE;
`endif
                end
            end
            default:   w_next = WAIT_CORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= WAIT_CORE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_data     <= '0;
            r_key      <= '0;
            r_rsp_data <= '0;
            r_seen_low <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= w_req_data[w_idx];
                r_key  <= w_req_key[w_idx];
                r_id   <= w_idx;
                r_ptr  <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == START)
                r_seen_low <= 1'b0;
            else if ((r_state == BUSY) && !core_done)
                r_seen_low <= 1'b1;
            if (w_done_ok)
                r_rsp_data <= core_result;
`ifdef TEA_ARB_TIMEOUT_EN
            else if (w_timeout)
                r_rsp_data <= '0;
`endif
        end
    end

    assign req_ready  = (r_state == ARB) ? w_grant : '0;
    assign core_start = (r_state == START);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_id;
    assign core_data  = r_data;
    assign core_key   = r_key;
    assign core_delta = DELTA;
    // Gated by reset so busy reads 0 while reset is held, even though state is WAIT_CORE.
    assign busy       = rst && (r_state != ARB);

endmodule
`default_nettype wire

// File: tb/tb_tea_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tea_arbiter: directed jobs against a behavioural TEA core and arbiter model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tea_arbiter;

    localparam int          N     = 4;
    localparam logic [31:0] DELTA = 32'h9E3779B9;
    localparam int          TO    = 40;

    logic             clk, rst, rsp_valid, rsp_ready, rsp_err, core_start, core_done, busy;
    logic [N-1:0]     req_valid, req_ready;
    logic [64*N-1:0]  req_data;
    logic [128*N-1:0] req_key;
    logic [63:0]      rsp_data, core_data, core_result;
    logic [1:0]       rsp_id;
    logic [127:0]     core_key;
    logic [31:0]      core_delta;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    tea_arbiter #(.NUM_REQ(N), .DELTA(DELTA), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .core_start(core_start), .core_data(core_data), .core_key(core_key),
        .core_delta(core_delta), .core_done(core_done), .core_result(core_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [127:0] k,
                                            input logic [31:0] dl);
        logic [31:0] y, z, s;
        y = d[63:32]; z = d[31:0]; s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            s = s + dl;
            y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32])  ^ (y + s) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Mock core: 0 nominal, 1 stale done for 3 cycles first, 2 never finishes.
    int          mode = 0;
    logic        kick = 1'b0;
    logic        m_done = 1'b1;
    logic [63:0] m_res = 64'd0, m_d = 64'd0;
    logic [127:0] m_k = 128'd0;
    int          m_cnt = 0, m_hold = 0;
    assign core_done   = m_done;
    assign core_result = m_res;

    always @(posedge clk) begin
        if (kick) begin
            m_done <= 1'b1; m_cnt <= 0; m_hold <= 0;
        end else if (core_start) begin
            m_d <= core_data; m_k <= core_key;
            if (mode == 1) begin m_done <= 1'b1; m_hold <= 3; m_cnt <= 0; end
            else begin m_done <= 1'b0; m_hold <= 0; m_cnt <= (mode == 2) ? 0 : 32; end
        end else if (m_hold != 0) begin
            if (m_hold == 1) begin m_done <= 1'b0; m_cnt <= 32; end
            m_hold <= m_hold - 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin m_done <= 1'b1; m_res <= tea_enc(m_d, m_k, core_delta); end
            m_cnt <= m_cnt - 1;
        end
    end

    // Transaction-level model of the arbiter, checked every cycle.
    int           m_ptr, m_acc, m_lat, m_id, m_arb_at, m_g;
    bit           m_pend, m_wait, m_prev_rv, m_in_arb, m_err;
    logic [63:0]  m_exp, m_last_d;
    logic [127:0] m_last_k;
    logic [N-1:0] m_exp_grant;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_ctrl", {busy, core_start, rsp_valid, rsp_err, req_ready, rsp_id}, 128'd0);
            check("rst_core_data", core_data, 128'd0);
            check("rst_core_key", core_key, 128'd0);
            check("rst_rsp_data", rsp_data, 128'd0);
            check("rst_delta", core_delta, DELTA);
            m_ptr = 0; m_pend = 0; m_wait = 1; m_prev_rv = 0; m_arb_at = 0;
            m_last_d = '0; m_last_k = '0;
        end else begin
            m_in_arb = !m_pend && !m_wait && (cyc >= m_arb_at);
            check("busy", busy, !m_in_arb);
            check("delta", core_delta, DELTA);
            check("core_data", core_data, m_last_d);
            check("core_key", core_key, m_last_k);
            check("core_start", core_start, m_pend && (cyc == m_acc + 1));
            m_g = m_in_arb ? rr_pick(req_valid, m_ptr) : -1;
            m_exp_grant = '0;
            if (m_g >= 0) m_exp_grant[m_g] = 1'b1;
            check("req_ready", req_ready, m_exp_grant);
            if (m_g >= 0) begin
                m_pend   = 1; m_acc = cyc; m_id = m_g; m_err = 0;
                m_last_d = req_data[m_g*64 +: 64];
                m_last_k = req_key[m_g*128 +: 128];
                m_exp    = tea_enc(m_last_d, m_last_k, DELTA);
                m_lat    = (mode == 1) ? 38 : 35;
`ifdef TEA_ARB_TIMEOUT_EN
                if (mode == 2) begin m_exp = '0; m_err = 1; m_lat = 2 + TO; end
`endif
                m_ptr = (m_g + 1) % N;
            end
            if (rsp_valid) begin
                check("rsp_expected", m_pend, 1'b1);
                if (!m_prev_rv) check("rsp_latency", cyc - m_acc, m_lat);
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_exp);
                check("rsp_err", rsp_err, m_err);
            end else if (m_pend && (cyc == m_acc + m_lat)) begin
                check("rsp_valid_due", rsp_valid, 1'b1);
            end
            if (m_wait && core_done) begin m_wait = 0; m_arb_at = cyc + 1; end
            if (rsp_valid && rsp_ready && m_pend) begin
                m_pend = 0;
                if (m_err) m_wait = 1; else m_arb_at = cyc + 1;
            end
            m_prev_rv = rsp_valid && !rsp_ready;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send(input int i, input logic [63:0] d, input logic [127:0] k);
        tick();
        req_data[i*64 +: 64]  = d;
        req_key[i*128 +: 128] = k;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_grant(output int g, output int c);
        g = -1; c = -1;
        for (int i = 0; i < 300 && g < 0; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) if (req_ready[j]) begin g = j; c = cyc; end
        end
        check("grant_seen", g >= 0, 1'b1);
    endtask

    task automatic wait_rsp(output logic [63:0] d, output int id, output logic e, output int c);
        c = -1; d = '0; id = -1; e = 1'b0;
        for (int i = 0; i < 300 && c < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin c = cyc; d = rsp_data; id = int'(rsp_id); e = rsp_err; end
        end
        check("rsp_seen", c >= 0, 1'b1);
    endtask

    int          g, ca, cr, id, hs;
    logic [63:0] d;
    logic        e;
    int          order [5] = '{0, 1, 2, 3, 2};

    initial begin
        clk = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_data = '0; req_key = '0;
        repeat (3) @(posedge clk); #1;
        check("reset_busy", busy, 1'b0);
        check("reset_delta", core_delta, 32'h9E3779B9);
        rst = 1'b1;

        // Single job, zero data/key: known TEA vector
        send(1, 64'd0, 128'd0);
        wait_grant(g, ca);
        check("t1_grant", g, 1);
        tick(); req_valid[1] = 1'b0;
        wait_rsp(d, id, e, cr);
        check("t1_data", d, 64'h41EA3A0A_94BAA940);
        check("t1_id", id, 1);
        check("t1_latency", cr - ca, 35);

        // Rewind pointer with a reset, then all four requesters at once
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            req_data[i*64 +: 64]  = {32'hDEAD_0000 + 32'(i), 32'hBEEF_0100 * 32'(i + 1)};
            req_key[i*128 +: 128] = {32'h0123_4567 + 32'(i), 32'h89AB_CDEF, 32'hFEDC_BA98 ^ 32'(i << 8), 32'h7654_3210};
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, ca);
            check($sformatf("t2_order%0d", k), g, order[k]);
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
            if (k == 2) begin
                req_data[2*64 +: 64] = 64'h0BAD_F00D_1234_5678;
                req_valid[2]         = 1'b1;
            end
        end
        wait_rsp(d, id, e, cr);
        check("t2_last_id", id, 2);

        // Backpressure: response held 10 extra cycles while requester 0 waits
        tick(); rsp_ready = 1'b0;
        send(3, 64'h0011_2233_4455_6677, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        wait_grant(g, ca);
        tick(); req_valid[3] = 1'b0;
        req_data[0 +: 64] = 64'hCAFE_BABE_0000_0001;
        req_valid[0] = 1'b1;
        wait_rsp(d, id, e, cr);
        check("t3_latency", cr - ca, 35);
        repeat (10) @(negedge clk);
        check("t3_hold_data", rsp_data, tea_enc(64'h0011_2233_4455_6677,
                                                128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, DELTA));
        tick(); rsp_ready = 1'b1; hs = cyc;
        wait_grant(g, ca);
        check("t3_grant", g, 0);
        check("t3_resume", ca, hs + 1);
        tick(); req_valid[0] = 1'b0;
        wait_rsp(d, id, e, cr);

        // Stale done: capture only on the second rising done
        tick(); mode = 1;
        send(1, 64'h1357_9BDF_2468_ACE0, {4{32'hA5A5_5A5A}});
        wait_grant(g, ca);
        tick(); req_valid[1] = 1'b0;
        wait_rsp(d, id, e, cr);
        check("t4_latency", cr - ca, 38);
        check("t4_id", id, 1);
        tick(); mode = 0;

        // Reset in BUSY cycle 10: silent abort, stale run drained in WAIT_CORE
        send(2, 64'h7777_8888_9999_AAAA, {32'h1, 32'h2, 32'h3, 32'h4});
        wait_grant(g, ca);
        tick(); req_valid[2] = 1'b0;
        while (cyc < ca + 11) tick();
        rst = 1'b0; #1;
        check("t5_rst_ctrl", {busy, core_start, rsp_valid, rsp_err, req_ready, rsp_id}, 128'd0);
        check("t5_rst_key", core_key, 128'd0);
        req_data[3*64 +: 64]  = 64'h5555_6666_7777_8888;
        req_key[3*128 +: 128] = {4{32'h3C3C_C3C3}};
        req_valid[3]          = 1'b1;
        tick(); rst = 1'b1;
        wait_grant(g, cr);
        check("t5_grant", g, 3);
        check("t5_grant_cyc", cr, ca + 35);
        tick(); req_valid[3] = 1'b0;
        wait_rsp(d, id, e, cr);
        check("t5_id", id, 3);

`ifdef TEA_ARB_TIMEOUT_EN
        // Core never finishes: error response, then back to WAIT_CORE
        tick(); mode = 2;
        send(0, 64'h1111_2222_3333_4444, {4{32'h0BAD_BEEF}});
        wait_grant(g, ca);
        tick(); req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        wait_rsp(d, id, e, cr);
        check("t6_err", e, 1'b1);
        check("t6_data", d, 64'd0);
        check("t6_latency", cr - ca, 2 + TO);
        repeat (5) @(negedge clk);
        check("t6_wait_busy", busy, 1'b1);
        tick(); kick = 1'b1; mode = 0;
        tick(); kick = 1'b0;
        wait_grant(g, ca);
        check("t6_grant", g, 1);
        tick(); req_valid[1] = 1'b0;
        wait_rsp(d, id, e, cr);
        check("t6_recover_err", e, 1'b0);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tea_arbiter.md
Name: tea_arbiter

Overview:
- Shares one TEA encryption core (64-bit block, 128-bit key, 32 rounds) between NUM_REQ requesters.
- Round-robin arbitration; each accepted job is latched, the core is sequenced with a one-cycle start pulse, the result is captured on core done, and it is returned on a single response channel tagged with the requester id.
- Sits between client blocks and the TEA core; owns the core's data, key, delta and start inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DELTA, 32'h9E3779B9, round constant driven to the core
- TIMEOUT_CYC, 40, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_data  in  64*NUM_REQ  plaintext {y,z}; requester i uses slice i
- req_key  in  128*NUM_REQ  key {k0,k1,k2,k3}; requester i uses slice i
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_data  out  64  ciphertext {y,z}
- rsp_id  out  $clog2(NUM_REQ)  originating requester
- rsp_err  out  1  timeout flag (tied 0 without the optional feature)
- core_start  out  1  start pulse to the core
- core_data  out  64  registered plaintext
- core_key  out  128  registered key, held for the whole job
- core_delta  out  32  constant DELTA
- core_done  in  1  core finished / idle
- core_result  in  64  core ciphertext
- busy  out  1  high in every state except ARB

Behaviour:
- Reset (rst=0, asynchronous) values:
  - All outputs 0 except core_delta=DELTA.
  - RR pointer = 0; state = WAIT_CORE.
- WAIT_CORE: wait for core_done=1, then go to ARB. This discards any stale core run in progress at reset.
- ARB:
  - Grant the first index with req_valid=1, searching from the pointer upward with wrap.
  - req_ready[g] is high for exactly that cycle; the transfer is valid&ready.
  - Latch req_data[g] and req_key[g] into core_data and core_key, and g into the id register.
  - Pointer becomes (g+1) mod NUM_REQ; go to START.
  - If no request is valid, stay in ARB with the pointer unchanged.
- START: core_start=1 for exactly one cycle; clear the seen_low flag; go to BUSY.
- BUSY:
  - Set seen_low when core_done=0.
  - When core_done=1 and seen_low=1, capture core_result into rsp_data and go to RESP.
  - core_done=1 before seen_low is set is ignored (the done is stale from the previous job).
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_valid&rsp_ready.
  - On that handshake, rsp_valid falls next cycle and the state goes to ARB.
  - No new grant is made while in RESP.
- Requester obligations: hold req_valid and its data/key stable until accepted. Dropping valid before a grant is legal.
- Latency with the nominal core: accept in cycle T, core_start in T+1, core_done rises in T+34, rsp_valid first high in T+35.
- rsp_ready held high: the next grant occurs in the cycle after the handshake.
- core_key and core_data change only in ARB on an accept.
- Reset mid-job: abort silently, no response; resume in WAIT_CORE.
- All requesters valid continuously: grant order 0,1,2,3,0,…; no starvation.

Optional Feature:
- Macro TEA_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY and clears on entry.
  - If it reaches TIMEOUT_CYC without an accepted done, go to RESP with rsp_err=1 and rsp_data=0, then return to WAIT_CORE (instead of ARB) after the handshake.
- Undefined: no counter; rsp_err is constant 0; BUSY waits indefinitely.

Decomposition:
- Package tea_pkg:
  - TEA_DELTA constant
  - TEA_ROUNDS=32
  - TEA_BLK_W=64 and TEA_KEY_W=128
  - state enum: WAIT_CORE, ARB, START, BUSY, RESP
- Sub-module tea_rr_arbiter (parameter N): inputs req vector and pointer; outputs one-hot grant and binary index; purely combinational.

Test Plan:
- Single job, real core:
  - Stimulus: requester 1 sends data=0, key=0 after reset.
  - Required: req_ready[1] pulses once; core_start one cycle later; rsp_valid 35 cycles after accept; rsp_data=64'h41EA3A0A_94BAA940; rsp_id=1.
- All four valid simultaneously with distinct keys:
  - Required: grants in order 0,1,2,3; each rsp_id and rsp_data matches the C reference model.
  - Follow-up: requester 2 re-asserts; the next grant is 2 only after 3 and 0 have been checked.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles in RESP.
  - Required: rsp_valid, rsp_data and rsp_id stable; no req_ready pulse; grant resumes the cycle after the handshake.
- Stale done:
  - Stimulus: mock core holds core_done=1 for 3 cycles after start, then low, then high.
  - Required: capture only on the second rising done.
- Reset mid-job:
  - Stimulus: rst=0 during BUSY cycle 10.
  - Required: all outputs zero immediately; no response for the aborted job; the next job completes correctly.
- Timeout (macro defined):
  - Stimulus: mock core never raises done.
  - Required: rsp_valid with rsp_err=1 and rsp_data=0 after TIMEOUT_CYC BUSY cycles; then WAIT_CORE.
